// File: rtl/lsu_axi_master.sv
// Load/store unit: accepts one memory request at a time and runs it over AXI AR/R or AW/W/B.
// Optional feature: define LSU_PERF_CNT_EN to add the perf_load_cnt/perf_store_cnt/perf_wait_cnt ports.
module lsu_axi_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_load_cnt,
    output logic [31:0]         perf_store_cnt,
    output logic [31:0]         perf_wait_cnt
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic                awDone_q, awDone_d;
    logic                wDone_q, wDone_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;

    logic                misaligned;
    logic [DATA_W-1:0]   laneData, laneMask, loadExt, storeData;
    logic                signBit;
    logic [STRB_W-1:0]   strbBase;

    // OKAY and EXOKAY both count as success; SLVERR/DECERR pass straight through.
    function automatic logic [1:0] mapResp(input logic [1:0] resp);
        return resp[1] ? resp : 2'b00;
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = (DATA_W == 32) || (|req_addr[2:0]);
        endcase
    end

    // Shift the addressed lane down to bit 0, then mask to size and extend.
    always_comb begin
        laneData = rdata >> {addr_q[OFF_W-1:0], 3'b000};
        laneMask = '1;
        signBit  = 1'b0;
        case (size_q)
            2'd0: begin
                laneMask = DATA_W'(64'h0000_0000_0000_00FF);
                signBit  = laneData[7];
            end
            2'd1: begin
                laneMask = DATA_W'(64'h0000_0000_0000_FFFF);
                signBit  = laneData[15];
            end
            2'd2: begin
                laneMask = DATA_W'(64'h0000_0000_FFFF_FFFF);
                signBit  = laneData[31];
            end
            default: begin
                laneMask = '1;
                signBit  = 1'b0;
            end
        endcase
        loadExt = (laneData & laneMask) | ((signed_q && signBit) ? ~laneMask : '0);
    end

    always_comb begin
        storeData = wdata_q;
        strbBase  = '1;
        case (size_q)
            2'd0: begin
                storeData = {STRB_W{wdata_q[7:0]}};
                strbBase  = STRB_W'(8'h01);
            end
            2'd1: begin
                storeData = {(DATA_W/16){wdata_q[15:0]}};
                strbBase  = STRB_W'(8'h03);
            end
            2'd2: begin
                storeData = {(DATA_W/32){wdata_q[31:0]}};
                strbBase  = STRB_W'(8'h0F);
            end
            default: begin
                storeData = wdata_q;
                strbBase  = STRB_W'(8'hFF);
            end
        endcase
    end

    // Next-state logic; request fields are only captured on acceptance so bus payloads stay frozen.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        signed_d = signed_q;
        awDone_d = awDone_q;
        wDone_d  = wDone_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size;
                    signed_d = req_signed;
                    awDone_d = 1'b0;
                    wDone_d  = 1'b0;
                    rdata_d  = '0;
                    if (misaligned) begin
                        err_d   = 2'b01;
                        state_d = DONE;
                    end else begin
                        err_d   = 2'b00;
                        state_d = req_we ? WR_REQ : RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid) begin
                    err_d   = mapResp(rresp);
                    rdata_d = rresp[1] ? '0 : loadExt;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                awDone_d = awDone_q | awready;
                wDone_d  = wDone_q | wready;
                if (awDone_d && wDone_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
                    err_d   = mapResp(bresp);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            awDone_q <= awDone_d;
            wDone_q  <= wDone_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign araddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign arvalid    = (state_q == RD_ADDR);
    assign rready     = (state_q == RD_DATA);
    assign awaddr     = addr_q;
    assign awsize     = {1'b0, size_q};
    assign awvalid    = (state_q == WR_REQ) && !awDone_q;
    assign wdata      = storeData;
    assign wstrb      = strbBase << addr_q[OFF_W-1:0];
    assign wvalid     = (state_q == WR_REQ) && !wDone_q;
    assign bready     = (state_q == WR_RESP);

`ifdef LSU_PERF_CNT_EN
    logic [31:0] loadCnt_q, storeCnt_q, waitCnt_q;

    // Completed bus transactions (errors included) and cycles spent waiting on the bus.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            loadCnt_q  <= '0;
            storeCnt_q <= '0;
            waitCnt_q  <= '0;
        end else begin
            if (state_q == RD_DATA && rvalid) loadCnt_q <= loadCnt_q + 32'd1;
            if (state_q == WR_RESP && bvalid) storeCnt_q <= storeCnt_q + 32'd1;
            if (state_q inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}) waitCnt_q <= waitCnt_q + 32'd1;
        end
    end

    assign perf_load_cnt  = loadCnt_q;
    assign perf_store_cnt = storeCnt_q;
    assign perf_wait_cnt  = waitCnt_q;
`endif

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: 32-bit instance driven from a vector table plus
// hand-written sequences, and a 64-bit instance for wide-lane loads.
module tb_lsu_axi_master;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    logic        req_valid64, req_ready64, req_signed64;
    logic [31:0] req_addr64;
    logic [1:0]  req_size64;
    logic        resp_valid64, resp_ready64;
    logic [63:0] resp_rdata64, rdata64, wdata64;
    logic [1:0]  resp_err64, rresp64;
    logic [31:0] araddr64, awaddr64;
    logic [2:0]  arsize64, awsize64;
    logic        arvalid64, arready64, rvalid64, rready64, awvalid64, wvalid64, bready64;
    logic [7:0]  wstrb64;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_load_cnt, perf_store_cnt, perf_wait_cnt;
    logic [31:0] perf_load_cnt64, perf_store_cnt64, perf_wait_cnt64;
`endif

    lsu_axi_master #(.DATA_W(32), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef LSU_PERF_CNT_EN
        , .perf_load_cnt(perf_load_cnt), .perf_store_cnt(perf_store_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    lsu_axi_master #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid64), .req_ready(req_ready64), .req_addr(req_addr64),
        .req_wdata(64'h0), .req_we(1'b0), .req_size(req_size64), .req_signed(req_signed64),
        .resp_valid(resp_valid64), .resp_ready(resp_ready64), .resp_rdata(resp_rdata64), .resp_err(resp_err64),
        .araddr(araddr64), .arsize(arsize64), .arvalid(arvalid64), .arready(arready64),
        .rdata(rdata64), .rresp(rresp64), .rvalid(rvalid64), .rready(rready64),
        .awaddr(awaddr64), .awsize(awsize64), .awvalid(awvalid64), .awready(1'b0),
        .wdata(wdata64), .wstrb(wstrb64), .wvalid(wvalid64), .wready(1'b0),
        .bresp(2'b00), .bvalid(1'b0), .bready(bready64)
`ifdef LSU_PERF_CNT_EN
        , .perf_load_cnt(perf_load_cnt64), .perf_store_cnt(perf_store_cnt64), .perf_wait_cnt(perf_wait_cnt64)
`endif
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] busData;
        logic [1:0]  busResp;
        logic [31:0] expRdata;
        logic [1:0]  expErr;
        logic [31:0] expWdata;
        logic [3:0]  expStrb;
        int          expLat;
        int          hold;
    } vec_t;

    localparam int NUM_VECS = 14;
    vec_t vecs[NUM_VECS];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Runs one 32-bit transaction against a zero-wait slave and checks bus payloads and the response.
    task automatic applyStimulus(input vec_t v, input int idx);
        int   lat;
        logic sawAr, sawAw, expBus;
        @(negedge clock);
        checkOutput($sformatf("v%0d req_ready", idx), req_ready, 1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdat;
        @(negedge clock);
        req_valid = 1'b0;
        lat   = 1;
        sawAr = 1'b0;
        sawAw = 1'b0;
        while (!resp_valid && lat < 20) begin
            if (arvalid) begin
                sawAr = 1'b1;
                checkOutput($sformatf("v%0d araddr", idx), araddr, v.addr);
                checkOutput($sformatf("v%0d arsize", idx), arsize, {1'b0, v.size});
            end
            if (awvalid) begin
                sawAw = 1'b1;
                checkOutput($sformatf("v%0d awaddr", idx), awaddr, v.addr);
            end
            if (wvalid) begin
                checkOutput($sformatf("v%0d wdata", idx), wdata, v.expWdata);
                checkOutput($sformatf("v%0d wstrb", idx), wstrb, v.expStrb);
            end
            arready = arvalid;
            rvalid  = rready;
            rdata   = v.busData;
            rresp   = v.busResp;
            awready = awvalid;
            wready  = wvalid;
            bvalid  = bready;
            bresp   = v.busResp;
            @(negedge clock);
            lat++;
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        expBus  = (v.expErr != 2'b01);
        checkOutput($sformatf("v%0d resp_valid", idx), resp_valid, 1);
        checkOutput($sformatf("v%0d latency", idx), 64'(lat), 64'(v.expLat));
        checkOutput($sformatf("v%0d ar_issued", idx), sawAr, expBus && !v.we);
        checkOutput($sformatf("v%0d aw_issued", idx), sawAw, expBus && v.we);
        for (int h = 0; h < v.hold; h++) begin
            checkOutput($sformatf("v%0d hold%0d resp_valid", idx, h), resp_valid, 1);
            checkOutput($sformatf("v%0d hold%0d resp_err", idx, h), resp_err, v.expErr);
            checkOutput($sformatf("v%0d hold%0d resp_rdata", idx, h), resp_rdata, v.expRdata);
            checkOutput($sformatf("v%0d hold%0d req_ready", idx, h), req_ready, 0);
            @(negedge clock);
        end
        checkOutput($sformatf("v%0d resp_rdata", idx), resp_rdata, v.expRdata);
        checkOutput($sformatf("v%0d resp_err", idx), resp_err, v.expErr);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        checkOutput($sformatf("v%0d resp_valid_after", idx), resp_valid, 0);
        checkOutput($sformatf("v%0d req_ready_after", idx), req_ready, 1);
    endtask

    task automatic load64(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [63:0] bus, input logic [63:0] expected, input string tag);
        @(negedge clock);
        req_valid64  = 1'b1;
        req_addr64   = addr;
        req_size64   = size;
        req_signed64 = sgn;
        @(negedge clock);
        req_valid64 = 1'b0;
        checkOutput({tag, " arvalid"}, arvalid64, 1);
        checkOutput({tag, " araddr"}, araddr64, addr);
        arready64 = 1'b1;
        @(negedge clock);
        arready64 = 1'b0;
        rvalid64  = 1'b1;
        rdata64   = bus;
        rresp64   = 2'b00;
        @(negedge clock);
        rvalid64 = 1'b0;
        checkOutput({tag, " resp_valid"}, resp_valid64, 1);
        checkOutput({tag, " resp_rdata"}, resp_rdata64, expected);
        checkOutput({tag, " resp_err"}, resp_err64, 0);
        resp_ready64 = 1'b1;
        @(negedge clock);
        resp_ready64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expLoads, expStores;
        //            we    size  sgn   addr          wdata         busData       rsp    expRdata      err    expWdata      strb  lat hold
        vecs[0]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,        32'h80FF_FF00, 2'b00, 32'hFFFF_FF80, 2'b00, 32'h0,        4'h0, 3, 0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,        32'h80FF_FF00, 2'b00, 32'h0000_0080, 2'b00, 32'h0,        4'h0, 3, 0};
        vecs[2]  = '{1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0,        32'h80FF_FF00, 2'b00, 32'hFFFF_80FF, 2'b00, 32'h0,        4'h0, 3, 0};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0,        32'h80FF_FF00, 2'b00, 32'h0000_80FF, 2'b00, 32'h0,        4'h0, 3, 0};
        vecs[4]  = '{1'b0, 2'd2, 1'b1, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 2'b01, 32'hDEAD_BEEF, 2'b00, 32'h0,        4'h0, 3, 0};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0,        32'h1234_5678, 2'b11, 32'h0,         2'b11, 32'h0,        4'h0, 3, 0};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0,        32'h0,         2'b00, 32'h0,         2'b01, 32'h0,        4'h0, 1, 0};
        vecs[7]  = '{1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0,        32'h0,         2'b00, 32'h0,         2'b01, 32'h0,        4'h0, 1, 0};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'hFFFF_1234, 32'h0,        2'b00, 32'h0,         2'b01, 32'h0,        4'h0, 1, 0};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h1234_565A, 32'h0,        2'b00, 32'h0,         2'b00, 32'h5A5A_5A5A, 4'h2, 3, 0};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,        2'b01, 32'h0,         2'b00, 32'hCAFE_F00D, 4'hF, 3, 0};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 32'h0,        2'b10, 32'h0,         2'b10, 32'hABCD_ABCD, 4'hC, 3, 4};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h8000_0001, 32'h0,        32'h0000_7F00, 2'b00, 32'h0000_007F, 2'b00, 32'h0,        4'h0, 3, 0};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h8000_0000, 32'h0,        32'h0000_00C3, 2'b10, 32'h0,         2'b10, 32'h0,        4'h0, 3, 0};

        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        req_valid64 = 1'b0; req_addr64 = '0; req_size64 = 2'd0; req_signed64 = 1'b0;
        resp_ready64 = 1'b0; arready64 = 1'b0; rvalid64 = 1'b0; rdata64 = '0; rresp64 = 2'b00;

        repeat (3) @(negedge clock);
        checkOutput("reset arvalid", arvalid, 0);
        checkOutput("reset awvalid", awvalid, 0);
        checkOutput("reset wvalid", wvalid, 0);
        checkOutput("reset resp_valid", resp_valid, 0);
        checkOutput("reset resp_rdata", resp_rdata, 0);
        checkOutput("reset resp_err", resp_err, 0);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("post-reset req_ready", req_ready, 1);
        checkOutput("post-reset req_ready64", req_ready64, 1);

        expLoads  = 0;
        expStores = 0;
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], i);
            if (vecs[i].expErr != 2'b01) begin
                if (vecs[i].we) expStores++;
                else expLoads++;
            end
        end

        // Half store where W is accepted first and AW two cycles later.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h8000_0002; req_wdata = 32'h0000_ABCD;
        @(negedge clock);
        req_valid = 1'b0;
        checkOutput("skew awvalid c1", awvalid, 1);
        checkOutput("skew wvalid c1", wvalid, 1);
        checkOutput("skew wdata", wdata, 32'hABCD_ABCD);
        checkOutput("skew wstrb", wstrb, 4'b1100);
        wready = 1'b1;
        @(negedge clock);
        wready = 1'b0;
        checkOutput("skew wvalid c2", wvalid, 0);
        checkOutput("skew awvalid c2", awvalid, 1);
        @(negedge clock);
        checkOutput("skew awvalid c3", awvalid, 1);
        checkOutput("skew bready c3", bready, 0);
        awready = 1'b1;
        @(negedge clock);
        awready = 1'b0;
        checkOutput("skew awvalid c4", awvalid, 0);
        checkOutput("skew bready c4", bready, 1);
        checkOutput("skew resp_valid c4", resp_valid, 0);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clock);
        bvalid = 1'b0;
        checkOutput("skew resp_valid", resp_valid, 1);
        checkOutput("skew resp_err", resp_err, 0);
        checkOutput("skew resp_rdata", resp_rdata, 0);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        checkOutput("skew single resp", resp_valid, 0);
        checkOutput("skew req_ready", req_ready, 1);
        @(negedge clock);
        checkOutput("skew no second resp", resp_valid, 0);
        expStores++;

`ifdef LSU_PERF_CNT_EN
        checkOutput("perf_load_cnt", perf_load_cnt, 32'(expLoads));
        checkOutput("perf_store_cnt", perf_store_cnt, 32'(expStores));
        checkOutput("perf_wait_cnt", perf_wait_cnt, 32'(2 * (expLoads + expStores - 1) + 4));
`endif

        load64(32'h8000_0004, 2'd2, 1'b0, 64'h1234_5678_0000_0000, 64'h0000_0000_1234_5678, "w64 uword");
        load64(32'h8000_0004, 2'd2, 1'b1, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, "w64 sword");
        load64(32'h8000_0008, 2'd3, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, "w64 dword");
        load64(32'h8000_0005, 2'd0, 1'b1, 64'h0000_F000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, "w64 sbyte");

        // Reset while the load waits in RD_DATA: the transaction is dropped without a response.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0020;
        @(negedge clock);
        req_valid = 1'b0;
        checkOutput("rst arvalid", arvalid, 1);
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        checkOutput("rst rready before", rready, 1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checkOutput("rst arvalid after", arvalid, 0);
        checkOutput("rst awvalid after", awvalid, 0);
        checkOutput("rst wvalid after", wvalid, 0);
        checkOutput("rst rready after", rready, 0);
        checkOutput("rst bready after", bready, 0);
        checkOutput("rst resp_valid after", resp_valid, 0);
        checkOutput("rst req_ready after", req_ready, 1);
`ifdef LSU_PERF_CNT_EN
        checkOutput("rst perf_load_cnt", perf_load_cnt, 0);
        checkOutput("rst perf_store_cnt", perf_store_cnt, 0);
        checkOutput("rst perf_wait_cnt", perf_wait_cnt, 0);
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput($sformatf("rst no resp c%0d", c), resp_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus data width; legal values are 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have port clock, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports req_valid (in, 1) and req_ready (out, 1): request handshake.
REQ-006 SHALL have request payload inputs: req_addr (ADDR_W), req_wdata (DATA_W), req_we (1; 1 = store), req_size (2; 0/1/2/3 = byte/half/word/dword), req_signed (1; sign-extend load).
REQ-007 SHALL have response ports: resp_valid (out, 1), resp_ready (in, 1), resp_rdata (out, DATA_W, extended load data), resp_err (out, 2; 00 ok, 01 misaligned, 10 SLVERR, 11 DECERR).
REQ-008 SHALL have AR channel ports: araddr (out, ADDR_W), arsize (out, 3), arvalid (out, 1), arready (in, 1).
REQ-009 SHALL have R channel ports: rdata (in, DATA_W), rresp (in, 2), rvalid (in, 1), rready (out, 1).
REQ-010 SHALL have AW channel ports: awaddr (out, ADDR_W), awsize (out, 3), awvalid (out, 1), awready (in, 1).
REQ-011 SHALL have W and B channel ports: wdata (out, DATA_W), wstrb (out, DATA_W/8), wvalid (out, 1), wready (in, 1), bresp (in, 2), bvalid (in, 1), bready (out, 1).

Function
REQ-012 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; req_ready = (state == IDLE).
REQ-013 SHALL register the full request on req_valid && req_ready; one transaction outstanding at a time.
REQ-014 SHALL treat an access as misaligned when address low bits are nonzero for its size (half: bit0; word: bits[1:0]; dword: bits[2:0]); req_size = 3 with DATA_W = 32 is misaligned.
REQ-015 SHALL send a misaligned request from IDLE directly to DONE with resp_err = 01, issuing no bus access.
REQ-016 SHALL send a load to RD_ADDR: arvalid high, araddr = req_addr, arsize = {0, req_size}; move to RD_DATA on arready.
REQ-017 SHALL hold rready high in RD_DATA; on rvalid, capture the lane-shifted rdata and rresp into response registers, then move to DONE.
REQ-018 SHALL select the load lane from addr[log2(DATA_W/8)-1:0], zero- or sign-extend per req_signed to DATA_W, and pass dword loads unextended.
REQ-019 SHALL, in WR_REQ, assert awvalid and wvalid independently; each drops after its own handshake; move to WR_RESP only when both are accepted, which may happen in the same or different cycles.
REQ-020 SHALL drive wdata with req_wdata replicated into the addressed lane and wstrb with the size-wide mask shifted by the address offset.
REQ-021 SHALL hold bready high in WR_RESP; on bvalid, capture bresp into resp_err and move to DONE.
REQ-022 SHALL map rresp/bresp 00 (OKAY) and 01 (EXOKAY) to resp_err = 00; 10 and 11 pass through unchanged.
REQ-023 SHALL, in DONE, hold resp_valid high with stable resp_rdata/resp_err until resp_ready, then go to IDLE; resp_rdata = 0 for stores and errors.
REQ-024 SHALL NOT drop valid on any AXI channel before its ready is seen, and SHALL NOT change payload while valid is high.
REQ-025 SHALL keep latency minimum, with 0-wait slaves: load 3 cycles from acceptance to resp_valid, store 3 cycles, misaligned 1 cycle.

Reset
REQ-026 SHALL, when reset_n is low at a clock edge, enter IDLE and clear arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_rdata and resp_err to 0; req_ready = 1 the cycle after release.
REQ-027 SHALL, on reset mid-transaction, abandon the transaction with no response.

Configuration
REQ-028 SHALL compile in performance counters when LSU_PERF_CNT_EN is defined: 32-bit output ports perf_load_cnt, perf_store_cnt, perf_wait_cnt.
REQ-029 SHALL update the counters as follows: load/store counts increment at completion (error included, misaligned excluded); wait count increments each cycle in RD_ADDR, RD_DATA, WR_REQ or WR_RESP; all counters wrap at 2^32 and clear on reset.
REQ-030 SHALL omit these ports and counters when LSU_PERF_CNT_EN is undefined, with no other behavioural change.

Verification
REQ-031 SHALL cover: DATA_W=32, signed byte load at 0x8000_0003, rdata 0x80FF_FF00, rresp 00 -> resp_rdata 0xFFFF_FF80, resp_err 00.
REQ-032 SHALL cover: half store 0xABCD at 0x8000_0002 -> wdata 0xABCD_ABCD, wstrb 1100; awready 2 cycles after wready -> single response after bvalid.
REQ-033 SHALL cover: word load at 0x8000_0001 -> resp_err 01 one cycle later; arvalid never asserted.
REQ-034 SHALL cover: store with bresp 10 -> resp_err 10, resp_rdata 0; resp_ready held low 4 cycles -> outputs stable, req_ready low.
REQ-035 SHALL cover: DATA_W=64, unsigned word load at offset 4, rdata 0x1234_5678_0000_0000 -> resp_rdata 0x0000_0000_1234_5678.
REQ-036 SHALL cover: reset_n low while in RD_DATA -> next cycle all valids 0, state IDLE; perf counters 0 when LSU_PERF_CNT_EN is defined.
